// File: rtl/ditl_pkg.sv
// Shared state type and size defaults for the HPGP turbo deinterleave buffer.
package ditl_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } ditl_state_e;

  localparam int D_WIDTH_DEF = 6;

  // Block lengths for the two HPGP PB sizes; PB520 needs A_WIDTH >= 12.
  localparam int BLK_LEN_PB136 = 544;
  localparam int BLK_LEN_PB520 = 2080;

endpackage

// File: rtl/ditl_dpram.sv
// Simple dual-port RAM: one write port, one read port with read enable and a
// registered read output that resets to zero (array contents are never cleared).
module ditl_dpram #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 10
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];
  logic [D_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register holds whenever rd_en is low, which gives the stall behaviour.
  always_ff @(posedge clk) begin
    if (srst)       rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/pb_deinterleave_buf.sv
// Block deinterleaver buffer: writes LLRs in arrival order, reads them back at
// ROM-supplied addresses. Define DITL_PINGPONG_EN for two banks (fill || drain).
module pb_deinterleave_buf
  import ditl_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = 10,
  parameter int BLK_LEN = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_last,
  output logic [A_WIDTH-1:0] rom_raddr,
  input  logic [A_WIDTH-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  output logic               blk_err
);

  localparam int CNT_W = A_WIDTH + 1;
`ifdef DITL_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_LEN - 1);
  localparam logic [CNT_W-1:0] BLK_END  = CNT_W'(BLK_LEN);

  ditl_state_e      state_reg, state_next;
  logic [CNT_W-1:0] wr_cnt_reg, wr_cnt_next;
  logic [CNT_W-1:0] rd_cnt_reg, rd_cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_last_reg, out_last_next;
  logic             blk_err_reg, blk_err_next;
  logic             fill_ok, accept, issue, blk_done, wr_en, rd_en;
  logic [D_WIDTH-1:0] rd_data [NUM_BANKS];

  assign accept = in_valid & fill_ok;

  // Write side: identical in both builds, only fill_ok differs.
  always_comb begin
    wr_cnt_next  = wr_cnt_reg;
    blk_err_next = 1'b0;
    blk_done     = 1'b0;
    wr_en        = 1'b0;
    if (accept) begin
      wr_en = 1'b1;
      if (wr_cnt_reg == LAST_IDX) begin
        wr_cnt_next  = '0;
        blk_done     = in_last;
        blk_err_next = ~in_last;
      end else if (in_last) begin
        wr_cnt_next  = '0;
        blk_err_next = 1'b1;
      end else begin
        wr_cnt_next = wr_cnt_reg + 1'b1;
      end
    end
  end

`ifdef DITL_PINGPONG_EN
  logic [1:0] full_reg, full_next;
  logic       fill_bank_reg, fill_bank_next;
  logic       drain_bank_reg, drain_bank_next;
  logic       out_bank_reg, out_bank_next;

  assign fill_ok = ~full_reg[fill_bank_reg];
  assign issue   = (state_reg == DRAIN) & full_reg[drain_bank_reg] & (~out_valid_reg | out_ready);

  // Drain bank is released at the last read issue so the next bank drains without a bubble.
  always_comb begin
    full_next       = full_reg;
    fill_bank_next  = fill_bank_reg;
    drain_bank_next = drain_bank_reg;
    out_bank_next   = out_bank_reg;
    rd_cnt_next     = rd_cnt_reg;
    out_valid_next  = out_valid_reg;
    out_last_next   = out_last_reg;
    rd_en           = 1'b0;
    if (blk_done) begin
      full_next[fill_bank_reg] = 1'b1;
      fill_bank_next           = ~fill_bank_reg;
    end
    if (issue) begin
      rd_en          = 1'b1;
      out_valid_next = 1'b1;
      out_bank_next  = drain_bank_reg;
      out_last_next  = (rd_cnt_reg == LAST_IDX);
      if (rd_cnt_reg == LAST_IDX) begin
        rd_cnt_next               = '0;
        full_next[drain_bank_reg] = 1'b0;
        drain_bank_next           = ~drain_bank_reg;
      end else begin
        rd_cnt_next = rd_cnt_reg + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
    state_next = (|full_next) ? DRAIN : FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg       <= '0;
      fill_bank_reg  <= 1'b0;
      drain_bank_reg <= 1'b0;
      out_bank_reg   <= 1'b0;
    end else begin
      full_reg       <= full_next;
      fill_bank_reg  <= fill_bank_next;
      drain_bank_reg <= drain_bank_next;
      out_bank_reg   <= out_bank_next;
    end
  end

  assign out_data = rd_data[out_bank_reg];
`else
  assign fill_ok = (state_reg == FILL);
  assign issue   = (state_reg == DRAIN) & (rd_cnt_reg < BLK_END) & (~out_valid_reg | out_ready);

  always_comb begin
    state_next     = state_reg;
    rd_cnt_next    = rd_cnt_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    rd_en          = 1'b0;
    case (state_reg)
      FILL: begin
        if (blk_done) state_next = DRAIN;
      end
      DRAIN: begin
        if (issue) begin
          rd_en          = 1'b1;
          out_valid_next = 1'b1;
          out_last_next  = (rd_cnt_reg == LAST_IDX);
          rd_cnt_next    = rd_cnt_reg + 1'b1;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
        end
        // Block is finished only once downstream has taken the last LLR.
        if (out_valid_reg & out_ready & out_last_reg) begin
          rd_cnt_next   = '0;
          out_last_next = 1'b0;
          state_next    = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign out_data = rd_data[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      blk_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_cnt_reg    <= wr_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      blk_err_reg   <= blk_err_next;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic bank_wr, bank_rd;
`ifdef DITL_PINGPONG_EN
    assign bank_wr = wr_en & (fill_bank_reg == 1'(gi));
    assign bank_rd = rd_en & (drain_bank_reg == 1'(gi));
`else
    assign bank_wr = wr_en;
    assign bank_rd = rd_en;
`endif
    ditl_dpram #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
    ) u_ram (
      .clk     (clk),
      .srst    (rst),
      .wr_en   (bank_wr),
      .wr_addr (wr_cnt_reg[A_WIDTH-1:0]),
      .wr_data (in_data),
      .rd_en   (bank_rd),
      .rd_addr (rom_data),
      .rd_data (rd_data[gi])
    );
  end

  assign in_ready  = fill_ok;
  assign rom_raddr = rd_cnt_reg[A_WIDTH-1:0];
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign blk_err   = blk_err_reg;

endmodule
